// File: rtl/trig_ctrl_pkg.sv
// rtl/trig_ctrl_pkg.sv - shared state encoding and 200 MHz timing defaults for the trigger chain
package trig_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE     = 2'd1,
    DEAD     = 2'd2,
    WAIT_DAQ = 2'd3
  } trig_state_e;

  localparam int OUT_LEN_DEF  = 6;
  localparam int GATE_LEN_DEF = 20;
  localparam int DEAD_MIN_DEF = 40;
  localparam int PS_W_DEF     = 8;
  localparam int CNT_W_DEF    = 32;

  // One down-counter serves both GATE and DEAD, so it must hold the larger terminal count.
  function automatic int tmr_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/trig_gate_sequencer_if.sv
// rtl/trig_gate_sequencer_if.sv - fire/DAQ inputs and trigger/gate outputs of the sequencer
// Optional lost_cnt member present when TRIG_LOSS_CNT_EN is defined.
interface trig_gate_sequencer_if
  import trig_ctrl_pkg::*;
#(
  parameter int PS_W  = PS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             fire_in;
  logic             enable;
  logic [PS_W-1:0]  prescale;
  logic             daq_busy;
  logic             trig_out;
  logic             gate_out;
  logic             busy_out;
  logic [CNT_W-1:0] trig_cnt;
`ifdef TRIG_LOSS_CNT_EN
  logic [CNT_W-1:0] lost_cnt;
`endif

  modport master (
    output fire_in, enable, prescale, daq_busy,
`ifdef TRIG_LOSS_CNT_EN
    input  lost_cnt,
`endif
    input  trig_out, gate_out, busy_out, trig_cnt
  );

  modport slave (
    input  fire_in, enable, prescale, daq_busy,
`ifdef TRIG_LOSS_CNT_EN
    output lost_cnt,
`endif
    output trig_out, gate_out, busy_out, trig_cnt
  );

endinterface

// File: rtl/trig_edge_prescaler.sv
// rtl/trig_edge_prescaler.sv - fire rising-edge detect, idle qualification and 1-of-N prescaler
// Optional saturating lost-edge counter when TRIG_LOSS_CNT_EN is defined.
module trig_edge_prescaler
  import trig_ctrl_pkg::*;
#(
  parameter int PS_W = PS_W_DEF
`ifdef TRIG_LOSS_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire_i,
  input  logic             enable_i,
  input  logic             idle_i,
  input  logic [PS_W-1:0]  prescale_i,
`ifdef TRIG_LOSS_CNT_EN
  output logic [CNT_W-1:0] lost_cnt_o,
`endif
  output logic             accept_o
);

  logic            f_q;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            rise_w;
  logic            qual_w;

  assign rise_w = fire_i & ~f_q;
  assign qual_w = rise_w & enable_i & idle_i;

  // >= rather than == so lowering prescale mid-run cannot strand ps_q above it.
  always_comb begin
    ps_d     = ps_q;
    accept_o = 1'b0;
    if (qual_w) begin
      if (ps_q >= prescale_i) begin
        accept_o = 1'b1;
        ps_d     = '0;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q  <= 1'b0;
      ps_q <= '0;
    end else begin
      f_q  <= fire_i;
      ps_q <= ps_d;
    end
  end

`ifdef TRIG_LOSS_CNT_EN
  logic [CNT_W-1:0] lost_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lost_q <= '0;
    end else if (rise_w && enable_i && !idle_i && (lost_q != '1)) begin
      lost_q <= lost_q + CNT_W'(1);
    end
  end

  assign lost_cnt_o = lost_q;
`endif

endmodule

// File: rtl/trig_gate_sequencer.sv
// rtl/trig_gate_sequencer.sv - one trigger per fire edge: trig pulse, MQDC gate, dead time, DAQ interlock
// Optional lost-edge counter enabled by macro TRIG_LOSS_CNT_EN.
module trig_gate_sequencer
  import trig_ctrl_pkg::*;
#(
  parameter int OUT_LEN  = OUT_LEN_DEF,
  parameter int GATE_LEN = GATE_LEN_DEF,
  parameter int DEAD_MIN = DEAD_MIN_DEF,
  parameter int PS_W     = PS_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  trig_gate_sequencer_if.slave  bus
);

  localparam int TMR_W = tmr_width(GATE_LEN, DEAD_MIN);

  trig_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             trig_q, trig_d;
  logic             gate_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  trig_edge_prescaler #(
    .PS_W (PS_W)
`ifdef TRIG_LOSS_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_edge_prescaler (
    .clk        (clk),
    .rst        (rst),
    .fire_i     (bus.fire_in),
    .enable_i   (bus.enable),
    .idle_i     (state_q == IDLE),
    .prescale_i (bus.prescale),
`ifdef TRIG_LOSS_CNT_EN
    .lost_cnt_o (bus.lost_cnt),
`endif
    .accept_o   (accept)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = GATE;
          tmr_d   = TMR_W'(GATE_LEN - 1);
        end
      end
      GATE: begin
        if (tmr_q == '0) begin
          state_d = DEAD;
          tmr_d   = TMR_W'(DEAD_MIN - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DEAD: begin
        if (tmr_q == '0) begin
          state_d = WAIT_DAQ;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      WAIT_DAQ: begin
        if (!bus.daq_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Elapsed gate cycles = GATE_LEN-1-tmr; the GATE qualifier truncates trig when OUT_LEN > GATE_LEN.
    trig_d = (state_d == GATE) && ((int'(tmr_d) + OUT_LEN) >= GATE_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      trig_q  <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      trig_q  <= trig_d;
      gate_q  <= (state_d == GATE);
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.trig_out = trig_q;
  assign bus.gate_out = gate_q;
  assign bus.busy_out = busy_q;
  assign bus.trig_cnt = cnt_q;

endmodule

// File: doc/trig_gate_sequencer.md
Name: trig_gate_sequencer

Overview:
Trigger controller behind the bar-OR fire logic. It turns the stretched `fire` level into one accepted trigger per event. It sequences three things: the short trigger pulse, the long MQDC gate, and a dead-time/DAQ-busy interlock. Fires arriving while the chain is busy are rejected. An optional prescaler thins the accepted rate. It sits between the bar OR network and the OutpA/OutpB output registers.

Parameters:
- OUT_LEN, 6, trig_out width in clk cycles (200 MHz → 30 ns).
- GATE_LEN, 20, gate_out width in clk cycles (100 ns).
- DEAD_MIN, 40, minimum dead cycles after gate end before DAQ busy is sampled.
- PS_W, 8, prescale register width.
- CNT_W, 32, accepted-trigger counter width.

Ports:
- clk  in  1  200 MHz system clock (CLK_PCLK_RIGHT).
- rst  in  1  synchronous reset, active-high.
- fire_in  in  1  stretched OR of front/rear bars; level, asynchronous to events.
- enable  in  1  run enable; qualifies new acceptances only.
- prescale  in  PS_W  accept 1 of (prescale+1) qualified edges; 0 = accept all.
- daq_busy  in  1  DAQ not ready; level.
- trig_out  out  1  registered trigger pulse, OUT_LEN cycles.
- gate_out  out  1  registered MQDC gate, GATE_LEN cycles.
- busy_out  out  1  high whenever state ≠ IDLE.
- trig_cnt  out  CNT_W  number of accepted triggers; wraps modulo 2^CNT_W.

Behaviour:
- Reset: state IDLE; all outputs 0; trig_cnt 0; prescale counter 0; edge register 0.
- Edge detect: f_q <= fire_in each cycle. edge = fire_in & ~f_q. A level held high yields exactly one edge.
- Qualified edge: edge & enable & state==IDLE.
- Prescaler, on a qualified edge:
  - if ps_cnt >= prescale: accept and set ps_cnt <= 0;
  - else: ps_cnt <= ps_cnt+1, no accept.
  - The >= compare makes a mid-run decrease of prescale safe.
- FSM:
  - IDLE: on accept (cycle n) → GATE. From cycle n+1: trig_out=1, gate_out=1, trig_cnt+1. Fixed latency: edge-to-outputs is 1 cycle.
  - GATE: down-counter starts at GATE_LEN-1. trig_out drops after OUT_LEN cycles. gate_out drops after GATE_LEN cycles. Then → DEAD. If OUT_LEN > GATE_LEN, trig_out is truncated at GATE_LEN.
  - DEAD: exactly DEAD_MIN cycles, then → WAIT_DAQ.
  - WAIT_DAQ: → IDLE in the first cycle daq_busy==0. If daq_busy is already 0, WAIT_DAQ lasts 1 cycle.
- Total busy window when the DAQ is idle: GATE_LEN + DEAD_MIN + 1 cycles.
- Edges outside IDLE are discarded. They do not advance the prescaler.
- enable dropping mid-sequence: the current sequence completes normally, and no new accepts follow.
- An edge in the same cycle the FSM returns to IDLE is not accepted. The first acceptable edge is in the cycle after busy_out falls.
- rst mid-sequence: outputs go to 0 in the next cycle. The partial gate is abandoned.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- Macro TRIG_LOSS_CNT_EN.
- Defined: adds output port lost_cnt [CNT_W-1:0]. It increments on every edge with enable=1 while state≠IDLE, saturates at all-ones, and clears on rst.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package trig_ctrl_pkg holds:
  - state encoding IDLE/GATE/DEAD/WAIT_DAQ (2-bit);
  - default constants for 200 MHz timing (OUT_LEN, GATE_LEN, DEAD_MIN);
  - CNT_W.
- One natural sub-module: trig_edge_prescaler. It contains the edge register, the qualification logic and ps_cnt, and outputs a single-cycle accept.

Test Plan:
- rst=1 for 3 cycles, enable=1, prescale=0, fire_in 0→1 held 6 cycles → trig_out high 6 cycles and gate_out high 20 cycles, both starting 1 cycle after the edge; trig_cnt=1; busy_out high 61 cycles.
- Second fire edge 10 cycles after the first (inside GATE) → no second trigger; trig_cnt stays 1; lost_cnt=1 with TRIG_LOSS_CNT_EN.
- prescale=3, 8 well-separated edges → triggers on edges 4 and 8 only; trig_cnt=2.
- daq_busy held high 100 cycles from the first edge → busy_out stays high until the cycle after daq_busy falls; an edge at that fall cycle is ignored, and an edge 1 cycle later is accepted.
- enable deasserted 5 cycles into GATE → gate completes (20 cycles); subsequent edges produce no triggers.
- rst asserted at gate cycle 10 → trig_out, gate_out and busy_out are 0 on the next cycle; trig_cnt=0; the next edge after rst release triggers normally.
